// File: rtl/a12_det_pkg.sv
// a12_det_pkg: default parameters and saturating-increment helper for the A12 scanline detector
package a12_det_pkg;
  localparam int A12_SYNC_DEF      = 2;
  localparam int A12_HIGH_MIN_DEF  = 2;
  localparam int A12_LOW_MIN_DEF   = 16;
  localparam int A12_FRAME_GAP_DEF = 4096;
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
    return (v >= max) ? max : v + 1;
  endfunction
endpackage

// File: rtl/a12_deglitch.sv
// a12_deglitch: SYNC_STAGES-flop synchroniser plus HIGH_MIN high-width filter; ports clk, rst, d (async in), s (synchronised), lvl (filtered level), rise (lvl rises next edge)
module a12_deglitch
  import a12_det_pkg::*;
#(
  parameter int SYNC_STAGES = A12_SYNC_DEF,
  parameter int HIGH_MIN    = A12_HIGH_MIN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic s,
  output logic lvl,
  output logic rise
);
  localparam int HW = $clog2(HIGH_MIN + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [HW-1:0] hi_cnt, hi_nxt;
  logic lvl_nxt;
  assign s = sync[SYNC_STAGES-1];
  assign hi_nxt = s ? HW'(sat_inc(32'(hi_cnt), HIGH_MIN)) : '0;
  // falls pass straight through because hi_nxt clears on the first low sample
  assign lvl_nxt = hi_nxt == HW'(HIGH_MIN);
  assign rise = lvl_nxt & ~lvl;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync   <= '0;
      hi_cnt <= '0;
      lvl    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], d};
      hi_cnt <= hi_nxt;
      lvl    <= lvl_nxt;
    end
endmodule

// File: rtl/a12_scanline_det.sv
// a12_scanline_det: PPU A12 deglitch, low-time edge qualification, scanline tick, line index and frame pulse
// Ports: clk, rst (async high), ppu_a12, m2 (async raw inputs), a12_lvl, a12_tick, line_ctr[7:0], frame_tick, rej_cnt[7:0]
// Option: define A12_M2_FILTER_EN to count low time in M2 falls instead of clk cycles
module a12_scanline_det
  import a12_det_pkg::*;
#(
  parameter int SYNC_STAGES = A12_SYNC_DEF,
  parameter int HIGH_MIN    = A12_HIGH_MIN_DEF,
  parameter int LOW_MIN     = A12_LOW_MIN_DEF,
  parameter int FRAME_GAP   = A12_FRAME_GAP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ppu_a12,
  input  logic       m2,
  output logic       a12_lvl,
  output logic       a12_tick,
  output logic [7:0] line_ctr,
  output logic       frame_tick,
  output logic [7:0] rej_cnt
);
  localparam int LW = $clog2(LOW_MIN + 1);
  localparam int GW = $clog2(FRAME_GAP + 1);
  logic a12_s, a12_rise, low_inc, tick_nxt, frame_nxt, unused;
  logic [LW-1:0] low_cnt;
  logic [GW-1:0] gap_cnt;
  a12_deglitch #(.SYNC_STAGES(SYNC_STAGES), .HIGH_MIN(HIGH_MIN)) u_a12 (
    .clk(clk), .rst(rst), .d(ppu_a12), .s(a12_s), .lvl(a12_lvl), .rise(a12_rise)
  );
`ifdef A12_M2_FILTER_EN
  logic m2_s, m2_prev, m2_rise;
  // HIGH_MIN=1 makes lvl a one-cycle-delayed copy of the synchronised m2
  a12_deglitch #(.SYNC_STAGES(SYNC_STAGES), .HIGH_MIN(1)) u_m2 (
    .clk(clk), .rst(rst), .d(m2), .s(m2_s), .lvl(m2_prev), .rise(m2_rise)
  );
  assign low_inc = m2_prev & ~m2_s;
  assign unused = a12_s ^ m2_rise;
`else
  assign low_inc = 1'b1;
  assign unused = a12_s ^ m2;
`endif
  assign tick_nxt  = a12_rise && low_cnt == LW'(LOW_MIN);
  // a tick on the expiry cycle restarts the gap, so no frame pulse then
  assign frame_nxt = !tick_nxt && gap_cnt == GW'(FRAME_GAP - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      low_cnt    <= '0;
      gap_cnt    <= '0;
      line_ctr   <= '0;
      rej_cnt    <= '0;
      a12_tick   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      low_cnt    <= a12_lvl ? '0 : low_inc ? LW'(sat_inc(32'(low_cnt), LOW_MIN)) : low_cnt;
      gap_cnt    <= tick_nxt ? '0 : GW'(sat_inc(32'(gap_cnt), FRAME_GAP));
      line_ctr   <= tick_nxt ? 8'(sat_inc(32'(line_ctr), 255)) : frame_nxt ? '0 : line_ctr;
      rej_cnt    <= (a12_rise && !tick_nxt) ? 8'(sat_inc(32'(rej_cnt), 255)) : rej_cnt;
      a12_tick   <= tick_nxt;
      frame_tick <= frame_nxt;
    end
endmodule

// File: tb/tb_a12_scanline_det.sv
// tb_a12_scanline_det: scoreboard bench; stimulus queues expected tick/frame events, a monitor pops and compares them
module tb_a12_scanline_det;
`ifdef A12_M2_FILTER_EN
  localparam int LM = 3;
`else
  localparam int LM = 16;
`endif
  logic clk = 1'b0, rst = 1'b1, ppu_a12 = 1'b0, m2 = 1'b0;
  logic a12_lvl, a12_tick, frame_tick;
  logic [7:0] line_ctr, rej_cnt;
  a12_scanline_det #(.SYNC_STAGES(2), .HIGH_MIN(2), .LOW_MIN(LM), .FRAME_GAP(4096)) dut (
    .clk(clk), .rst(rst), .ppu_a12(ppu_a12), .m2(m2), .a12_lvl(a12_lvl), .a12_tick(a12_tick),
    .line_ctr(line_ctr), .frame_tick(frame_tick), .rej_cnt(rej_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {bit frm; int cyc; int line; int rej;} ev_t;
  ev_t q[$];
  int checks = 0, failures = 0;
  int exp_line = 0, exp_rej = 0, t_last = 0;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (!rst && (a12_tick || frame_tick)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: tick=%0b frame=%0b at cyc %0d, none expected", a12_tick, frame_tick, cyc);
      end else begin
        e = q.pop_front();
        chk("ev_frame", frame_tick, e.frm);
        chk("ev_tick", a12_tick, !e.frm);
        chk("ev_cyc", cyc, e.cyc);
        chk("ev_line", line_ctr, e.line);
        chk("ev_rej", rej_cnt, e.rej);
      end
    end
  end
  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic expect_edge(bit good);
    if (good) begin
      exp_line = exp_line < 255 ? exp_line + 1 : 255;
      t_last = cyc + 4;
      q.push_back('{frm: 1'b0, cyc: t_last, line: exp_line, rej: exp_rej});
    end else exp_rej++;
  endtask
  task automatic pulse(int low_n, int high_n, bit good);
    ppu_a12 = 1'b0;
    step(low_n);
    expect_edge(good);
    ppu_a12 = 1'b1;
    step(high_n);
  endtask
  task automatic m2_span(int falls, bit good);
    ppu_a12 = 1'b0;
    step(6);
    repeat (falls) begin
      m2 = 1'b1;
      step(2);
      m2 = 1'b0;
      step(2);
    end
    step(4);
    expect_edge(good);
    ppu_a12 = 1'b1;
    step(10);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    bit seen;
    int t1;
    step(3);
    chk("rst_lvl", a12_lvl, 0);
    chk("rst_tick", a12_tick, 0);
    chk("rst_frame", frame_tick, 0);
    chk("rst_line", line_ctr, 0);
    chk("rst_rej", rej_cnt, 0);
    rst = 1'b0;
`ifdef A12_M2_FILTER_EN
    m2_span(3, 1);
    m2_span(2, 0);
    chk("m2_rej_two_falls", rej_cnt, 1);
    chk("m2_line_after_rej", line_ctr, 1);
    m2_span(3, 1);
    chk("m2_line_three_falls", line_ctr, 2);
`else
    pulse(20, 10, 1);
    chk("first_line", line_ctr, 1);
    chk("first_rej", rej_cnt, 0);
    pulse(10, 10, 0);
    chk("short_low_rej", rej_cnt, 1);
    chk("short_low_line", line_ctr, 1);
    pulse(15, 10, 0);
    chk("low15_rej", rej_cnt, 2);
    pulse(16, 10, 1);
    chk("low16_line", line_ctr, 2);
    ppu_a12 = 1'b0;
    step(20);
    ppu_a12 = 1'b1;
    step(1);
    ppu_a12 = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      step(1);
      seen |= a12_lvl;
    end
    chk("glitch_lvl", seen, 0);
    chk("glitch_rej", rej_cnt, 2);
    pulse(2, 10, 1);
    chk("after_glitch_line", line_ctr, 3);
    repeat (300) pulse(20, 20, 1);
    chk("sat_line", line_ctr, 255);
    chk("sat_rej", rej_cnt, 2);
    ppu_a12 = 1'b0;
    exp_line = 0;
    q.push_back('{frm: 1'b1, cyc: t_last + 4096, line: 0, rej: exp_rej});
    while (cyc < t_last + 4120) step(1);
    chk("frame_line", line_ctr, 0);
    pulse(20, 10, 1);
    t1 = t_last;
    ppu_a12 = 1'b0;
    while (cyc < t1 + 4092) step(1);
    expect_edge(1);
    ppu_a12 = 1'b1;
    q.push_back('{frm: 1'b1, cyc: t_last + 4096, line: 0, rej: exp_rej});
    while (cyc < t_last + 4120) step(1);
    chk("frame2_line", line_ctr, 0);
`endif
    for (int i = 0; i < 100 && q.size() > 0; i++) step(1);
    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
